// File: rtl/frame_pkg.sv
// Shared definitions for the frame packetizer: state encoding, default widths, config helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package frame_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] META    = 2'd2;
  localparam logic [1:0] TRAILER = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_PAYLOAD = PAYLOAD,
    S_META    = META,
    S_TRAILER = TRAILER
  } state_e;

  localparam int DEF_DW       = 128;
  localparam int DEF_CNT_W    = 64;
  localparam int DEF_PKT_W    = 32;
  localparam int DEF_META_MAX = 4;

  // Payload beats per frame; a zero divisor or a zero quotient still yields one beat
  // so a frame can never be empty of payload.
  function automatic logic [31:0] safe_div(input logic [31:0] frame_size,
                                           input logic [15:0] packet_size);
    logic [31:0] q;
    q = 32'd1;
    if (packet_size != 16'd0) begin
      q = frame_size / {16'd0, packet_size};
      if (q == 32'd0) q = 32'd1;
    end
    return q;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI-Stream output register with a load_ok qualifier for the producer.
// Latency: 1 cycle from load to tvalid.
// Backpressure: holds tdata/tlast/tkeep stable while tvalid && !tready; load_ok low then.
module axis_out_reg
  import frame_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_vld_i,
  input  logic [DW-1:0] load_dat_i,
  input  logic          load_last_i,
  output logic          load_ok_o,
  output logic [DW-1:0] tdata_o,
  output logic          tvalid_o,
  output logic          tlast_o,
  output logic [DW/8-1:0] tkeep_o,
  input  logic          tready_i
);

  logic [DW-1:0]   tdata_q;
  logic            tvalid_q;
  logic            tlast_q;
  logic [DW/8-1:0] tkeep_q;

  assign load_ok_o = !tvalid_q || tready_i;
  assign tdata_o   = tdata_q;
  assign tvalid_o  = tvalid_q;
  assign tlast_o   = tlast_q;
  assign tkeep_o   = tkeep_q;

  // Register a new beat whenever the slot is empty or being drained this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tkeep_q  <= '0;
    end else if (load_ok_o) begin
      tvalid_q <= load_vld_i;
      tlast_q  <= load_vld_i && load_last_i;
      tkeep_q  <= {(DW/8){load_vld_i}};
      if (load_vld_i) tdata_q <= load_dat_i;
    end
  end

endmodule

// File: rtl/frame_packetizer.sv
// Frame builder: N payload beats, M metadata beats, then a frame-counter trailer with tlast.
// Latency: 1 cycle from input handshake to axis_out_tvalid; back-to-back frames without gaps.
// Backpressure: input treadys follow the output register's load_ok; FSM stalls on any beat.
module frame_packetizer
  import frame_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int META_MAX = DEF_META_MAX,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PKT_W    = DEF_PKT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   frame_size,
  input  logic [15:0]                   packet_size,
  input  logic [$clog2(META_MAX+1)-1:0] meta_len,
  input  logic                          enable,
  input  logic [DW-1:0]                 axis_in_tdata,
  input  logic                          axis_in_tvalid,
  output logic                          axis_in_tready,
  input  logic [DW-1:0]                 axis_in_meta_tdata,
  input  logic                          axis_in_meta_tvalid,
  output logic                          axis_in_meta_tready,
  output logic [DW-1:0]                 axis_out_tdata,
  output logic                          axis_out_tvalid,
  input  logic                          axis_out_tready,
  output logic                          axis_out_tlast,
  output logic [DW/8-1:0]               axis_out_tkeep,
  output logic [1:0]                    fsm_state,
  output logic [CNT_W-1:0]              frame_count
);

  localparam int MLW = $clog2(META_MAX+1);

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   n_pkt_q, n_pkt_d;
  logic [MLW-1:0]     meta_n_q, meta_n_d;
  logic [PKT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [MLW-1:0]     meta_cnt_q, meta_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               load_ok;
  logic               ld_vld;
  logic [DW-1:0]      ld_dat;
  logic               ld_last;
  logic [PKT_W-1:0]   cfg_n_pkt;
  logic [MLW-1:0]     cfg_meta;

  assign cfg_n_pkt = PKT_W'(safe_div(frame_size, packet_size));
  assign cfg_meta  = (meta_len > MLW'(META_MAX)) ? MLW'(META_MAX) : meta_len;

  assign axis_in_tready      = load_ok && (state_q == S_PAYLOAD);
  assign axis_in_meta_tready = load_ok && (state_q == S_META);
  assign fsm_state           = state_q;
  assign frame_count         = frame_cnt_q;

  // State, latched frame config and beat/frame counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_pkt_q     <= '0;
      meta_n_q    <= '0;
      pkt_cnt_q   <= '0;
      meta_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      n_pkt_q     <= n_pkt_d;
      meta_n_q    <= meta_n_d;
      pkt_cnt_q   <= pkt_cnt_d;
      meta_cnt_q  <= meta_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic; also selects which beat (if any) goes into the output register.
  always_comb begin
    state_d     = state_q;
    n_pkt_d     = n_pkt_q;
    meta_n_d    = meta_n_q;
    pkt_cnt_d   = pkt_cnt_q;
    meta_cnt_d  = meta_cnt_q;
    frame_cnt_d = frame_cnt_q;
    ld_vld      = 1'b0;
    ld_dat      = axis_in_tdata;
    ld_last     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          n_pkt_d    = cfg_n_pkt;
          meta_n_d   = cfg_meta;
          pkt_cnt_d  = '0;
          meta_cnt_d = '0;
          state_d    = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (axis_in_tvalid && axis_in_tready) begin
          ld_vld = 1'b1;
          ld_dat = axis_in_tdata;
          if (pkt_cnt_q == n_pkt_q - PKT_W'(1)) begin
            pkt_cnt_d = '0;
            state_d   = (meta_n_q != '0) ? S_META : S_TRAILER;
          end else begin
            pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
          end
        end
      end
      S_META: begin
        if (axis_in_meta_tvalid && axis_in_meta_tready) begin
          ld_vld = 1'b1;
          ld_dat = axis_in_meta_tdata;
          if (meta_cnt_q == meta_n_q - MLW'(1)) begin
            meta_cnt_d = '0;
            state_d    = S_TRAILER;
          end else begin
            meta_cnt_d = meta_cnt_q + MLW'(1);
          end
        end
      end
      S_TRAILER: begin
        if (load_ok) begin
          ld_vld      = 1'b1;
          ld_dat      = DW'(frame_cnt_q);
          ld_last     = 1'b1;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          pkt_cnt_d   = '0;
          meta_cnt_d  = '0;
          if (enable) begin
            n_pkt_d  = cfg_n_pkt;
            meta_n_d = cfg_meta;
            state_d  = S_PAYLOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  axis_out_reg #(.DW(DW)) u_out_reg (
    .clk         (clk),
    .rst         (reset),
    .load_vld_i  (ld_vld),
    .load_dat_i  (ld_dat),
    .load_last_i (ld_last),
    .load_ok_o   (load_ok),
    .tdata_o     (axis_out_tdata),
    .tvalid_o    (axis_out_tvalid),
    .tlast_o     (axis_out_tlast),
    .tkeep_o     (axis_out_tkeep),
    .tready_i    (axis_out_tready)
  );

endmodule
